// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch front end.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 32'hBFC0_0000;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_EXC_PC   = 32'hBFC0_0380;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] inst;
    logic                    fault;
  } fetch_entry_t;

  function automatic logic [FETCH_ADDR_W-1:0] pc4(input logic [FETCH_ADDR_W-1:0] pc);
    return pc + FETCH_ADDR_W'(4);
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus: redirect inputs, SRAM request/response and the decode-side queue port.
interface if_fetch_queue_if #(
  parameter int ADDR_W = fetch_pkg::FETCH_ADDR_W,
  parameter int DATA_W = fetch_pkg::FETCH_DATA_W
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              exc_valid;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc4;
  logic [DATA_W-1:0] out_inst;
  logic              out_addr_fault;

  modport master (
    input  redirect_valid, redirect_pc, exc_valid, req_ready, resp_valid, resp_data, out_ready,
    output req_valid, req_addr, out_valid, out_pc, out_pc4, out_inst, out_addr_fault
  );

  modport slave (
    output redirect_valid, redirect_pc, exc_valid, req_ready, resp_valid, resp_data, out_ready,
    input  req_valid, req_addr, out_valid, out_pc, out_pc4, out_inst, out_addr_fault
  );
endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with clear and occupancy count; push while full is legal with a same-cycle pop.
module fetch_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            wdata,
  output logic [W-1:0]            rdata,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupled fetch front end: credit-limited PC generator, in-order response queue, flush on redirect.
// Optional IF_FETCH_PERF_EN adds saturating perf_fetched / perf_discarded / perf_starve counters.
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [ADDR_W-1:0] EXC_PC   = FETCH_EXC_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  if_fetch_queue_if.master  bus
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_discarded,
  output logic [31:0]       perf_starve
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("if_fetch_queue: DEPTH must be a power of 2 in 2..16");
  end

  logic [ADDR_W-1:0] fetch_pc;
  logic              halted;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;

  logic [CW-1:0]     q_count;
  logic [CW-1:0]     pc_count;
  logic [EW-1:0]     q_wdata;
  logic [EW-1:0]     q_rdata;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_inst;
  logic              head_fault;
  logic [CW:0]       in_use;

  logic redir, aligned, credit, issue, accept, mis_push;
  logic resp_in, resp_keep, resp_drop, q_valid, pop;

  assign redir   = bus.exc_valid || bus.redirect_valid;
  assign aligned = (fetch_pc[1:0] == 2'b00);
  assign in_use  = {1'b0, q_count} + {1'b0, outstanding};
  assign credit  = in_use < (CW+1)'(DEPTH);
  assign issue   = rst_n && !halted && !redir && credit;
  assign accept  = issue && aligned && bus.req_ready;
  // A fault entry waits until every kept response ahead of it has landed, preserving program order.
  assign mis_push = issue && !aligned && (outstanding == discard);

  // Stray responses with nothing in flight are ignored so the counters cannot underflow.
  assign resp_in   = rst_n && bus.resp_valid && (outstanding != '0);
  assign resp_keep = resp_in && (discard == '0);
  assign resp_drop = resp_in && (discard != '0);

  assign q_valid = rst_n && (q_count != '0);
  assign pop     = q_valid && bus.out_ready;
  assign q_wdata = resp_keep ? {inflight_pc, bus.resp_data, 1'b0}
                             : {fetch_pc, {DATA_W{1'b0}}, 1'b1};

  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redir),
    .push  (resp_keep || mis_push),
    .pop   (pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (q_count)
  );

  // PCs of kept in-flight requests; discarded ones are older and never enter after a flush.
  fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_inflight (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redir),
    .push  (accept),
    .pop   (resp_keep),
    .wdata (fetch_pc),
    .rdata (inflight_pc),
    .count (pc_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      halted      <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redir) begin
      fetch_pc    <= bus.exc_valid ? EXC_PC : bus.redirect_pc;
      halted      <= 1'b0;
      outstanding <= outstanding - CW'(resp_in);
      discard     <= outstanding - CW'(resp_in);
    end else begin
      if (accept)   fetch_pc <= fetch_pc + ADDR_W'(4);
      if (mis_push) halted   <= 1'b1;
      outstanding <= outstanding + CW'(accept) - CW'(resp_in);
      discard     <= discard - CW'(resp_drop);
    end
  end

  assign {head_pc, head_inst, head_fault} = q_rdata;

  assign bus.req_valid      = issue && aligned;
  assign bus.req_addr       = (issue && aligned) ? fetch_pc : '0;
  assign bus.out_valid      = q_valid;
  assign bus.out_pc         = q_valid ? head_pc : '0;
  assign bus.out_pc4        = q_valid ? head_pc + ADDR_W'(4) : '0;
  assign bus.out_inst       = q_valid ? head_inst : '0;
  assign bus.out_addr_fault = q_valid && head_fault;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.resp_valid && outstanding == '0))
        else $error("if_fetch_queue: response received with no request outstanding");
      assert (pc_count == outstanding - discard)
        else $error("if_fetch_queue: in-flight PC tracking out of step with counters");
    end
  end

`ifdef IF_FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
      perf_starve    <= '0;
    end else begin
      perf_fetched   <= sat_inc(perf_fetched, pop);
      perf_discarded <= sat_inc(perf_discarded, resp_drop);
      perf_starve    <= sat_inc(perf_starve, bus.out_ready && !q_valid);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: SRAM responder model plus a scoreboard on the decode port.
module tb_if_fetch_queue;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_discarded, perf_starve;
`endif

  if_fetch_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded),
    .perf_starve    (perf_starve)
`endif
  );

  int tests = 0;
  int fails = 0;

  fetch_entry_t sb[$];
  logic [31:0]  pend_addr[$];
  int           pend_due[$];
  int           cyc = 0;
  int           lat = 1;
  bit           resp_en = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %08h required %08h", name, act, exp);
    end
  endtask

  // SRAM responder: records accepts seen before an edge, replies in order after lat cycles.
  initial begin
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.req_valid && bus.req_ready) begin
        pend_addr.push_back(bus.req_addr);
        pend_due.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (resp_en && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
      end
    end
  end

  // Decode-side monitor.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst_n === 1'b1 && bus.out_valid && bus.out_ready) begin
      check("pop_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_pc", bus.out_pc, e.pc);
        check("out_pc4", bus.out_pc4, pc4(e.pc));
        check("out_inst", bus.out_inst, e.inst);
        check("out_addr_fault", 32'(bus.out_addr_fault), 32'(e.fault));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int n, input logic [31:0] start, input bit keep, output int cycles);
    int got = 0;
    logic [31:0] a;
    cycles = 0;
    bus.req_ready = 1'b1;
    while (got < n && cycles < 200) begin
      @(negedge clk);
      if (bus.req_valid) begin
        a = start + 32'(4 * got);
        check("req_addr", bus.req_addr, a);
        if (keep) sb.push_back(fetch_entry_t'{pc: a, inst: mem_word(a), fault: 1'b0});
        got++;
      end
      step();
      cycles++;
    end
    bus.req_ready = 1'b0;
    check("issue_count", 32'(got), 32'(n));
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || pend_addr.size() != 0 || bus.out_valid) && t < 100) begin
      step();
      t++;
    end
    check("idle_reached", 32'(t < 100), 32'd1);
  endtask

  task automatic pulse(input bit rv, input bit ev, input logic [31:0] pc);
    bus.redirect_valid = rv;
    bus.exc_valid      = ev;
    bus.redirect_pc    = pc;
    bus.req_ready      = 1'b1;
    #1;
    check("req_valid_on_redirect", 32'(bus.req_valid), 32'd0);
    step();
    bus.redirect_valid = 1'b0;
    bus.exc_valid      = 1'b0;
    bus.req_ready      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, 32'(bus.req_valid), 32'd0);
    check({tag, "_req_addr"}, bus.req_addr, 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_pc"}, bus.out_pc, 32'd0);
    check({tag, "_out_pc4"}, bus.out_pc4, 32'd0);
    check({tag, "_out_inst"}, bus.out_inst, 32'd0);
    check({tag, "_out_fault"}, 32'(bus.out_addr_fault), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int used;
    int acc;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.exc_valid      = 1'b0;
    bus.req_ready      = 1'b0;
    bus.out_ready      = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_all_zero("reset");
    step();
    rst_n = 1'b1;
    #1;
    check("first_req_valid", 32'(bus.req_valid), 32'd1);
    check("first_req_addr", bus.req_addr, 32'hBFC0_0000);

    // Streaming at one entry per cycle.
    lat = 1;
    resp_en = 1'b1;
    bus.out_ready = 1'b1;
    issue(6, 32'hBFC0_0000, 1'b1, used);
    check("stream_cycles", 32'(used), 32'd6);
    wait_idle();

    // Decode stalled: credit stops issue after DEPTH accepts.
    bus.out_ready = 1'b0;
    bus.req_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_valid) begin
        check("blocked_req_addr", bus.req_addr, 32'hBFC0_0018 + 32'(4 * acc));
        sb.push_back(fetch_entry_t'{pc: 32'hBFC0_0018 + 32'(4 * acc),
                                    inst: mem_word(32'hBFC0_0018 + 32'(4 * acc)), fault: 1'b0});
        acc++;
      end
      step();
    end
    check("blocked_accepts", 32'(acc), 32'd4);
    @(negedge clk);
    check("blocked_req_valid", 32'(bus.req_valid), 32'd0);
    check("blocked_out_valid", 32'(bus.out_valid), 32'd1);
    check("blocked_head_pc", bus.out_pc, 32'hBFC0_0018);
    bus.req_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    check("blocked_head_held", bus.out_pc, 32'hBFC0_0018);
    step();
    bus.out_ready = 1'b1;
    wait_idle();
    issue(2, 32'hBFC0_0028, 1'b1, used);
    wait_idle();

    // Redirect with three requests in flight: their responses are dropped.
    resp_en = 1'b0;
    issue(3, 32'hBFC0_0030, 1'b0, used);
    pulse(1'b1, 1'b0, 32'h8000_0100);
    resp_en = 1'b1;
    issue(3, 32'h8000_0100, 1'b1, used);
    wait_idle();
`ifdef IF_FETCH_PERF_EN
    check("perf_discarded", perf_discarded, 32'd3);
`endif

    // Exception wins over a same-cycle redirect.
    pulse(1'b1, 1'b1, 32'h8000_0000);
    issue(2, 32'hBFC0_0380, 1'b1, used);
    wait_idle();

    // Misaligned redirect target yields one fault entry and no SRAM request.
    pulse(1'b1, 1'b0, 32'h8000_0002);
    sb.push_back(fetch_entry_t'{pc: 32'h8000_0002, inst: 32'h0, fault: 1'b1});
    bus.req_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.req_valid) acc++;
      step();
    end
    bus.req_ready = 1'b0;
    check("misaligned_requests", 32'(acc), 32'd0);
    wait_idle();
    pulse(1'b0, 1'b1, 32'h0);
    issue(2, 32'hBFC0_0380, 1'b1, used);
    wait_idle();

    // Reset mid-stream with two requests outstanding; their responses land during reset.
    lat = 3;
    issue(2, 32'hBFC0_0388, 1'b0, used);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (4) step();
    rst_n = 1'b1;
    #1;
    check("late_resp_drained", 32'(pend_addr.size()), 32'd0);
    check("restart_req_addr", bus.req_addr, 32'hBFC0_0000);
    check("restart_out_valid", 32'(bus.out_valid), 32'd0);
    lat = 1;
    issue(2, 32'hBFC0_0000, 1'b1, used);
    wait_idle();
`ifdef IF_FETCH_PERF_EN
    check("perf_fetched_after_reset", perf_fetched, 32'd2);
    check("perf_discarded_after_reset", perf_discarded, 32'd0);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
